// File: rtl/arp_eth_tx.sv
// ARP frame transmitter: latches ARP header fields, presents them as an Ethernet
// header and serialises the 28-byte ARP payload onto an 8-bit AXI stream.
module arp_eth_tx (
  input  logic        clk,
  input  logic        rst,

  input  logic        s_frame_valid,
  output logic        s_frame_ready,
  input  logic [47:0] s_eth_dest_mac,
  input  logic [47:0] s_eth_src_mac,
  input  logic [15:0] s_eth_type,
  input  logic [15:0] s_arp_htype,
  input  logic [15:0] s_arp_ptype,
  input  logic [15:0] s_arp_oper,
  input  logic [47:0] s_arp_sha,
  input  logic [31:0] s_arp_spa,
  input  logic [47:0] s_arp_tha,
  input  logic [31:0] s_arp_tpa,

  output logic        m_eth_hdr_valid,
  input  logic        m_eth_hdr_ready,
  output logic [47:0] m_eth_dest_mac,
  output logic [47:0] m_eth_src_mac,
  output logic [15:0] m_eth_type,

  output logic [7:0]  m_eth_payload_axis_tdata,
  output logic        m_eth_payload_axis_tvalid,
  input  logic        m_eth_payload_axis_tready,
  output logic        m_eth_payload_axis_tlast,
  output logic        m_eth_payload_axis_tuser,

  output logic        busy
);

  // Every handshake transfers on a rising edge where valid && ready; a valid
  // source holds its data unchanged until that edge, and ready may depend on nothing.
  typedef enum logic {IDLE = 1'b0, WRITE_PAYLOAD = 1'b1} state_t;

  localparam logic [4:0] LAST_PTR = 5'd27;

  state_t      state_q, state_d;
  logic [4:0]  ptr_q, ptr_d;
  logic        frame_ready_q, frame_ready_d;
  logic        hdr_valid_q, hdr_valid_d;
  logic [47:0] dest_q, dest_d;
  logic [47:0] src_q, src_d;
  logic [15:0] type_q, type_d;
  logic [15:0] htype_q, htype_d;
  logic [15:0] ptype_q, ptype_d;
  logic [15:0] oper_q, oper_d;
  logic [47:0] sha_q, sha_d;
  logic [31:0] spa_q, spa_d;
  logic [47:0] tha_q, tha_d;
  logic [31:0] tpa_q, tpa_d;
  logic [7:0]  tdata_q, tdata_d;
  logic        tvalid_q, tvalid_d;
  logic        tlast_q, tlast_d;
  logic        busy_q, busy_d;

  logic [7:0]  cur_byte;
  logic        load_en;

  always_comb begin
    cur_byte = 8'h00;
    case (ptr_q)
      5'd0:  cur_byte = htype_q[15:8];
      5'd1:  cur_byte = htype_q[7:0];
      5'd2:  cur_byte = ptype_q[15:8];
      5'd3:  cur_byte = ptype_q[7:0];
      5'd4:  cur_byte = 8'h06;
      5'd5:  cur_byte = 8'h04;
      5'd6:  cur_byte = oper_q[15:8];
      5'd7:  cur_byte = oper_q[7:0];
      5'd8:  cur_byte = sha_q[47:40];
      5'd9:  cur_byte = sha_q[39:32];
      5'd10: cur_byte = sha_q[31:24];
      5'd11: cur_byte = sha_q[23:16];
      5'd12: cur_byte = sha_q[15:8];
      5'd13: cur_byte = sha_q[7:0];
      5'd14: cur_byte = spa_q[31:24];
      5'd15: cur_byte = spa_q[23:16];
      5'd16: cur_byte = spa_q[15:8];
      5'd17: cur_byte = spa_q[7:0];
      5'd18: cur_byte = tha_q[47:40];
      5'd19: cur_byte = tha_q[39:32];
      5'd20: cur_byte = tha_q[31:24];
      5'd21: cur_byte = tha_q[23:16];
      5'd22: cur_byte = tha_q[15:8];
      5'd23: cur_byte = tha_q[7:0];
      5'd24: cur_byte = tpa_q[31:24];
      5'd25: cur_byte = tpa_q[23:16];
      5'd26: cur_byte = tpa_q[15:8];
      5'd27: cur_byte = tpa_q[7:0];
      default: cur_byte = 8'h00;
    endcase
  end

  // The single output register may be refilled whenever it is empty or being drained.
  assign load_en = !tvalid_q || m_eth_payload_axis_tready;

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    hdr_valid_d = hdr_valid_q;
    dest_d      = dest_q;
    src_d       = src_q;
    type_d      = type_q;
    htype_d     = htype_q;
    ptype_d     = ptype_q;
    oper_d      = oper_q;
    sha_d       = sha_q;
    spa_d       = spa_q;
    tha_d       = tha_q;
    tpa_d       = tpa_q;
    tdata_d     = tdata_q;
    tvalid_d    = tvalid_q;
    tlast_d     = tlast_q;

    if (hdr_valid_q && m_eth_hdr_ready) begin
      hdr_valid_d = 1'b0;
    end

    if (tvalid_q && m_eth_payload_axis_tready) begin
      tvalid_d = 1'b0;
      tlast_d  = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (s_frame_valid && frame_ready_q) begin
          dest_d      = s_eth_dest_mac;
          src_d       = s_eth_src_mac;
          type_d      = s_eth_type;
          htype_d     = s_arp_htype;
          ptype_d     = s_arp_ptype;
          oper_d      = s_arp_oper;
          sha_d       = s_arp_sha;
          spa_d       = s_arp_spa;
          tha_d       = s_arp_tha;
          tpa_d       = s_arp_tpa;
          hdr_valid_d = 1'b1;
          ptr_d       = 5'd0;
          state_d     = WRITE_PAYLOAD;
        end
      end
      WRITE_PAYLOAD: begin
        if (load_en) begin
          tdata_d  = cur_byte;
          tvalid_d = 1'b1;
          tlast_d  = (ptr_q == LAST_PTR);
          if (ptr_q == LAST_PTR) begin
            ptr_d   = 5'd0;
            state_d = IDLE;
          end else begin
            ptr_d = ptr_q + 5'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // A new frame is taken only once back in IDLE and the previous header has gone.
    frame_ready_d = (state_d == IDLE) && !hdr_valid_d;
    busy_d        = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      ptr_q         <= 5'd0;
      frame_ready_q <= 1'b0;
      hdr_valid_q   <= 1'b0;
      dest_q        <= 48'h0;
      src_q         <= 48'h0;
      type_q        <= 16'h0;
      htype_q       <= 16'h0;
      ptype_q       <= 16'h0;
      oper_q        <= 16'h0;
      sha_q         <= 48'h0;
      spa_q         <= 32'h0;
      tha_q         <= 48'h0;
      tpa_q         <= 32'h0;
      tdata_q       <= 8'h0;
      tvalid_q      <= 1'b0;
      tlast_q       <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      frame_ready_q <= frame_ready_d;
      hdr_valid_q   <= hdr_valid_d;
      dest_q        <= dest_d;
      src_q         <= src_d;
      type_q        <= type_d;
      htype_q       <= htype_d;
      ptype_q       <= ptype_d;
      oper_q        <= oper_d;
      sha_q         <= sha_d;
      spa_q         <= spa_d;
      tha_q         <= tha_d;
      tpa_q         <= tpa_d;
      tdata_q       <= tdata_d;
      tvalid_q      <= tvalid_d;
      tlast_q       <= tlast_d;
      busy_q        <= busy_d;
    end
  end

  assign s_frame_ready             = frame_ready_q;
  assign m_eth_hdr_valid           = hdr_valid_q;
  assign m_eth_dest_mac            = dest_q;
  assign m_eth_src_mac             = src_q;
  assign m_eth_type                = type_q;
  assign m_eth_payload_axis_tdata  = tdata_q;
  assign m_eth_payload_axis_tvalid = tvalid_q;
  assign m_eth_payload_axis_tlast  = tlast_q;
  assign m_eth_payload_axis_tuser  = 1'b0;
  assign busy                      = busy_q;

endmodule

// File: tb/tb_arp_eth_tx.sv
// Bench for arp_eth_tx: scenario tasks drive frames, a negedge monitor pops the
// expected payload/header queues and checks ordering, stability and tuser.
module tb_arp_eth_tx;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        s_frame_valid = 1'b0;
  logic        s_frame_ready;
  logic [47:0] s_eth_dest_mac = '0;
  logic [47:0] s_eth_src_mac = '0;
  logic [15:0] s_eth_type = '0;
  logic [15:0] s_arp_htype = '0;
  logic [15:0] s_arp_ptype = '0;
  logic [15:0] s_arp_oper = '0;
  logic [47:0] s_arp_sha = '0;
  logic [31:0] s_arp_spa = '0;
  logic [47:0] s_arp_tha = '0;
  logic [31:0] s_arp_tpa = '0;
  logic        m_eth_hdr_valid;
  logic        m_eth_hdr_ready = 1'b0;
  logic [47:0] m_eth_dest_mac;
  logic [47:0] m_eth_src_mac;
  logic [15:0] m_eth_type;
  logic [7:0]  tdata;
  logic        tvalid;
  logic        tready;
  logic        tlast;
  logic        tuser;
  logic        busy;

  typedef struct {
    logic [47:0] dest;
    logic [47:0] src;
    logic [15:0] etype;
    logic [15:0] htype;
    logic [15:0] ptype;
    logic [15:0] oper;
    logic [47:0] sha;
    logic [31:0] spa;
    logic [47:0] tha;
    logic [31:0] tpa;
  } frame_t;

  logic [8:0]   exp_q[$];
  logic [111:0] hdr_exp_q[$];
  logic [7:0]   pay[$];

  int tests_run = 0;
  int tests_failed = 0;
  int beats = 0;
  int tlast_cnt = 0;
  int cyc = 0;
  int last_tlast_cyc = 0;

  bit rdy_rand = 1'b0;
  bit rdy_fix = 1'b0;
  bit rnd_bit = 1'b0;

  bit         stall_prev = 1'b0;
  logic [7:0] prev_data = '0;
  logic       prev_last = 1'b0;

  arp_eth_tx dut (
    .clk                       (clk),
    .rst                       (rst),
    .s_frame_valid             (s_frame_valid),
    .s_frame_ready             (s_frame_ready),
    .s_eth_dest_mac            (s_eth_dest_mac),
    .s_eth_src_mac             (s_eth_src_mac),
    .s_eth_type                (s_eth_type),
    .s_arp_htype               (s_arp_htype),
    .s_arp_ptype               (s_arp_ptype),
    .s_arp_oper                (s_arp_oper),
    .s_arp_sha                 (s_arp_sha),
    .s_arp_spa                 (s_arp_spa),
    .s_arp_tha                 (s_arp_tha),
    .s_arp_tpa                 (s_arp_tpa),
    .m_eth_hdr_valid           (m_eth_hdr_valid),
    .m_eth_hdr_ready           (m_eth_hdr_ready),
    .m_eth_dest_mac            (m_eth_dest_mac),
    .m_eth_src_mac             (m_eth_src_mac),
    .m_eth_type                (m_eth_type),
    .m_eth_payload_axis_tdata  (tdata),
    .m_eth_payload_axis_tvalid (tvalid),
    .m_eth_payload_axis_tready (tready),
    .m_eth_payload_axis_tlast  (tlast),
    .m_eth_payload_axis_tuser  (tuser),
    .busy                      (busy)
  );

  // ---------------- clock / reset / background ----------------
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    rnd_bit = ($urandom_range(0, 1) == 1);
  end

  assign tready = rdy_rand ? rnd_bit : rdy_fix;

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (!rst) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        tests_run++;
        if ({tvalid, tlast, tdata} !== {1'b1, prev_last, prev_data}) begin
          tests_failed++;
          $display("[TB] FAIL stall_hold: got valid/last/data=%b/%b/%h, required 1/%b/%h",
                   tvalid, tlast, tdata, prev_last, prev_data);
        end
      end
      if (tvalid && tready) begin
        tests_run++;
        if (exp_q.size() == 0) begin
          tests_failed++;
          $display("[TB] FAIL unexpected_beat: got data=%h last=%b, required no beat", tdata, tlast);
        end else begin
          logic [8:0] e;
          e = exp_q.pop_front();
          if ({tuser, tlast, tdata} !== {1'b0, e}) begin
            tests_failed++;
            $display("[TB] FAIL payload_beat: got user/last/data=%b/%b/%h, required 0/%b/%h",
                     tuser, tlast, tdata, e[8], e[7:0]);
          end
        end
        beats++;
        if (tlast) begin
          tlast_cnt++;
          last_tlast_cyc = cyc;
        end
      end
      if (m_eth_hdr_valid && m_eth_hdr_ready) begin
        tests_run++;
        if (hdr_exp_q.size() == 0) begin
          tests_failed++;
          $display("[TB] FAIL unexpected_hdr: got dest=%h, required no header", m_eth_dest_mac);
        end else begin
          logic [111:0] h;
          h = hdr_exp_q.pop_front();
          if ({m_eth_dest_mac, m_eth_src_mac, m_eth_type} !== h) begin
            tests_failed++;
            $display("[TB] FAIL hdr_fields: got %h, required %h",
                     {m_eth_dest_mac, m_eth_src_mac, m_eth_type}, h);
          end
        end
      end
      stall_prev = tvalid && !tready;
      prev_data  = tdata;
      prev_last  = tlast;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push_bytes(input logic [47:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) pay.push_back(v[8*i +: 8]);
  endtask

  task automatic model_payload(input frame_t f);
    push_bytes({32'h0, f.htype}, 2);
    push_bytes({32'h0, f.ptype}, 2);
    push_bytes(48'h0604, 2);
    push_bytes({32'h0, f.oper}, 2);
    push_bytes(f.sha, 6);
    push_bytes({16'h0, f.spa}, 4);
    push_bytes(f.tha, 6);
    push_bytes({16'h0, f.tpa}, 4);
  endtask

  function automatic frame_t rand_frame(input logic [15:0] oper);
    frame_t f;
    logic [63:0] t;
    t = {$urandom, $urandom}; f.dest = t[47:0];
    t = {$urandom, $urandom}; f.src  = t[47:0];
    t = {$urandom, $urandom}; f.sha  = t[47:0];
    t = {$urandom, $urandom}; f.tha  = t[47:0];
    f.spa   = $urandom;
    f.tpa   = $urandom;
    f.etype = 16'h0806;
    f.htype = 16'h0001;
    f.ptype = 16'h0800;
    f.oper  = oper;
    return f;
  endfunction

  // Caller leaves pay empty to use the field model, or pre-loads it with literal bytes.
  task automatic send_frame(input frame_t f, output int acc);
    bit ok;
    s_eth_dest_mac = f.dest;
    s_eth_src_mac  = f.src;
    s_eth_type     = f.etype;
    s_arp_htype    = f.htype;
    s_arp_ptype    = f.ptype;
    s_arp_oper     = f.oper;
    s_arp_sha      = f.sha;
    s_arp_spa      = f.spa;
    s_arp_tha      = f.tha;
    s_arp_tpa      = f.tpa;
    s_frame_valid  = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (s_frame_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    tests_run++;
    if (!ok) begin
      tests_failed++;
      $display("[TB] FAIL accept_timeout: got s_frame_ready=%b, required 1 within 200 cycles", s_frame_ready);
    end
    if (pay.size() == 0) model_payload(f);
    for (int i = 0; i < pay.size(); i++) exp_q.push_back({(i == pay.size() - 1), pay[i]});
    pay.delete();
    hdr_exp_q.push_back({f.dest, f.src, f.etype});
    @(posedge clk);
    #1;
    acc = cyc;
    s_frame_valid = 1'b0;
  endtask

  task automatic wait_drain(input int budget, input bit with_hdr, input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      #1;
      if (exp_q.size() == 0 && (!with_hdr || hdr_exp_q.size() == 0)) begin
        ok = 1'b1;
        break;
      end
    end
    tests_run++;
    if (!ok) begin
      tests_failed++;
      $display("[TB] FAIL %s_drain: got %0d bytes and %0d headers outstanding, required 0",
               name, exp_q.size(), hdr_exp_q.size());
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    tests_run++;
    if ({s_frame_ready, m_eth_hdr_valid, tvalid, tlast, tuser, busy} !== 6'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_ctrl: got rdy/hv/tv/tl/tu/busy=%b, required 000000",
               {s_frame_ready, m_eth_hdr_valid, tvalid, tlast, tuser, busy});
    end
    tests_run++;
    if ({tdata, m_eth_dest_mac, m_eth_src_mac, m_eth_type} !== 120'h0) begin
      tests_failed++;
      $display("[TB] FAIL reset_data: got %h, required 0",
               {tdata, m_eth_dest_mac, m_eth_src_mac, m_eth_type});
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    tests_run++;
    if ({s_frame_ready, tvalid} !== 2'b10) begin
      tests_failed++;
      $display("[TB] FAIL reset_release: got ready/tvalid=%b, required 10", {s_frame_ready, tvalid});
    end
  endtask

  task automatic test_basic();
    frame_t f;
    int acc, t0;
    logic [7:0] lit [28];
    lit = '{8'h00, 8'h01, 8'h08, 8'h00, 8'h06, 8'h04, 8'h00, 8'h01,
            8'h5A, 8'h51, 8'h52, 8'h53, 8'h54, 8'h55, 8'hC0, 8'hA8, 8'h01, 8'h64,
            8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hC0, 8'hA8, 8'h01, 8'h80};
    f.dest = 48'hFFFF_FFFF_FFFF; f.src = 48'h5A51_5253_5455; f.etype = 16'h0806;
    f.htype = 16'h0001; f.ptype = 16'h0800; f.oper = 16'h0001;
    f.sha = 48'h5A51_5253_5455; f.spa = 32'hC0A8_0164;
    f.tha = 48'h0; f.tpa = 32'hC0A8_0180;
    rdy_rand = 1'b0; rdy_fix = 1'b1; m_eth_hdr_ready = 1'b1;
    for (int i = 0; i < 28; i++) pay.push_back(lit[i]);
    t0 = tlast_cnt;
    send_frame(f, acc);
    tests_run++;
    if ({m_eth_hdr_valid, busy, s_frame_ready, tvalid} !== 4'b1100) begin
      tests_failed++;
      $display("[TB] FAIL basic_after_accept: got hv/busy/rdy/tv=%b, required 1100",
               {m_eth_hdr_valid, busy, s_frame_ready, tvalid});
    end
    tests_run++;
    if ({m_eth_dest_mac, m_eth_src_mac, m_eth_type} !== {f.dest, f.src, f.etype}) begin
      tests_failed++;
      $display("[TB] FAIL basic_hdr_latch: got %h, required %h",
               {m_eth_dest_mac, m_eth_src_mac, m_eth_type}, {f.dest, f.src, f.etype});
    end
    @(posedge clk);
    #1;
    tests_run++;
    if ({tvalid, tdata} !== {1'b1, 8'h00}) begin
      tests_failed++;
      $display("[TB] FAIL basic_first_byte: got tvalid/tdata=%b/%h, required 1/00", tvalid, tdata);
    end
    wait_drain(100, 1'b1, "basic");
    tests_run++;
    if (tlast_cnt - t0 != 1 || last_tlast_cyc - acc != 28) begin
      tests_failed++;
      $display("[TB] FAIL basic_tlast: got count=%0d at offset %0d, required count=1 at offset 28",
               tlast_cnt - t0, last_tlast_cyc - acc);
    end
    tests_run++;
    if ({busy, s_frame_ready} !== 2'b01) begin
      tests_failed++;
      $display("[TB] FAIL basic_idle: got busy/rdy=%b, required 01", {busy, s_frame_ready});
    end
  endtask

  task automatic test_backpressure();
    int acc, b0, t0;
    b0 = beats; t0 = tlast_cnt;
    rdy_rand = 1'b1; m_eth_hdr_ready = 1'b1;
    for (int n = 0; n < 2; n++) begin
      send_frame(rand_frame(16'(n + 1)), acc);
      wait_drain(600, 1'b1, "backpressure");
    end
    rdy_rand = 1'b0; rdy_fix = 1'b1;
    tests_run++;
    if (beats - b0 != 56 || tlast_cnt - t0 != 2) begin
      tests_failed++;
      $display("[TB] FAIL backpressure_count: got beats=%0d tlast=%0d, required 56/2",
               beats - b0, tlast_cnt - t0);
    end
  endtask

  task automatic test_header_stall();
    frame_t f;
    int acc, bad, t0;
    f = rand_frame(16'h0002);
    rdy_rand = 1'b0; rdy_fix = 1'b1; m_eth_hdr_ready = 1'b0;
    t0 = tlast_cnt;
    send_frame(f, acc);
    bad = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (m_eth_hdr_valid !== 1'b1 || s_frame_ready !== 1'b0 ||
          {m_eth_dest_mac, m_eth_src_mac, m_eth_type} !== {f.dest, f.src, f.etype}) bad++;
    end
    tests_run++;
    if (bad != 0) begin
      tests_failed++;
      $display("[TB] FAIL hdr_stall_hold: got %0d bad cycles, required 0", bad);
    end
    tests_run++;
    if (exp_q.size() != 0 || tlast_cnt - t0 != 1 || busy !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL hdr_stall_payload: got left=%0d tlast=%0d busy=%b, required 0/1/0",
               exp_q.size(), tlast_cnt - t0, busy);
    end
    m_eth_hdr_ready = 1'b1;
    @(posedge clk);
    #1;
    tests_run++;
    if ({m_eth_hdr_valid, s_frame_ready} !== 2'b01 || hdr_exp_q.size() != 0) begin
      tests_failed++;
      $display("[TB] FAIL hdr_stall_release: got hv/rdy=%b hdr_left=%0d, required 01/0",
               {m_eth_hdr_valid, s_frame_ready}, hdr_exp_q.size());
    end
  endtask

  task automatic test_back_to_back();
    int acc1, acc2, b0, t0;
    rdy_rand = 1'b0; rdy_fix = 1'b1; m_eth_hdr_ready = 1'b1;
    b0 = beats; t0 = tlast_cnt;
    send_frame(rand_frame(16'h0001), acc1);
    send_frame(rand_frame(16'h0002), acc2);
    tests_run++;
    if (acc2 - acc1 != 29) begin
      tests_failed++;
      $display("[TB] FAIL b2b_spacing: got %0d cycles, required 29", acc2 - acc1);
    end
    wait_drain(100, 1'b1, "b2b");
    tests_run++;
    if (beats - b0 != 56 || tlast_cnt - t0 != 2) begin
      tests_failed++;
      $display("[TB] FAIL b2b_count: got beats=%0d tlast=%0d, required 56/2",
               beats - b0, tlast_cnt - t0);
    end
  endtask

  task automatic test_reset_mid_frame();
    int acc, b0, t0;
    rdy_rand = 1'b0; rdy_fix = 1'b1; m_eth_hdr_ready = 1'b1;
    b0 = beats; t0 = tlast_cnt;
    send_frame(rand_frame(16'h0001), acc);
    for (int i = 0; i < 100; i++) begin
      if (beats - b0 >= 11) break;
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
    #1;
    tests_run++;
    if ({tvalid, busy} !== 2'b00) begin
      tests_failed++;
      $display("[TB] FAIL midreset_async: got tvalid/busy=%b, required 00", {tvalid, busy});
    end
    exp_q.delete();
    hdr_exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    tests_run++;
    if (tvalid !== 1'b0 || tlast_cnt != t0) begin
      tests_failed++;
      $display("[TB] FAIL midreset_no_resume: got tvalid=%b tlast=%0d, required 0/%0d",
               tvalid, tlast_cnt - t0, 0);
    end
    send_frame(rand_frame(16'h0002), acc);
    wait_drain(100, 1'b1, "after_reset");
    tests_run++;
    if (tlast_cnt - t0 != 1) begin
      tests_failed++;
      $display("[TB] FAIL after_reset_tlast: got %0d, required 1", tlast_cnt - t0);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_header_stall();
    test_back_to_back();
    test_reset_mid_frame();
    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
